serial_sub: RTL and testbench

- Parametrised bit-serial subtractor computing diff = a - b over WIDTH bits, one bit per clock, LSB first.
- Each bit uses a full subtractor: the half-subtractor borrow logic extended with a borrow-in.
- Start/busy/done handshake; the result and final borrow are held until the next operation.
- Intended as the low-area arithmetic primitive for multi-cycle datapaths.

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/full_sub.sv | 21 ++
 rtl/serial_sub.sv | 116 +++++++++++
 tb/tb_serial_sub.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State encoding is fixed at 00/01/10 so external probes can decode it.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   // One spare bit means the counter never wraps for any legal WIDTH.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/full_sub.sv
// Combinational one-bit full subtractor: d = a - b - bin.
// Built from two half subtractors whose borrows are ORed together.
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_d1;
   logic w_b1;
   logic w_b2;

   assign w_d1 = a ^ b;
   assign w_b1 = ~a & b;
   assign d    = w_d1 ^ bin;
   assign w_b2 = ~w_d1 & bin;
   assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, one bit per clock, start/busy/done handshake.
// Define SERIAL_SUB_SIGNED_EN to add the registered two's-complement overflow output ovf.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
`ifdef SERIAL_SUB_SIGNED_EN
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done
);

   localparam int              CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_e           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_bin;
   logic             r_borrow;
`ifdef SERIAL_SUB_SIGNED_EN
   logic             r_ovf;
`endif

   logic             w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_res_next;

   full_sub u_full_sub (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_bin),
      .d    (w_d),
      .bout (w_bout)
   );

   // New difference bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign w_res_next = w_d;
      end else begin : g_res_wn
         assign w_res_next = {w_d, r_res[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_bin    <= 1'b0;
         r_borrow <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_bin   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_res <= w_res_next;
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_bin <= w_bout;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_diff   <= w_res_next;
                  r_borrow <= w_bout;
`ifdef SERIAL_SUB_SIGNED_EN
                  // On the last bit r_a[0]/r_b[0] are the original operand MSBs.
                  r_ovf    <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
`endif
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign diff   = r_diff;
   assign borrow = r_borrow;
`ifdef SERIAL_SUB_SIGNED_EN
   assign ovf    = r_ovf;
`endif
   assign busy   = (r_state != IDLE);
   assign done   = (r_state == DONE);

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: arithmetic reference model plus directed and random ops.
// Build with SERIAL_SUB_SIGNED_EN defined to also cover the ovf output.
module tb_serial_sub;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic [W-1:0] diff;
   logic         borrow;
   logic         busy;
   logic         done;
`ifdef SERIAL_SUB_SIGNED_EN
   logic         ovf;
`endif

   always #5 clk = ~clk;

   serial_sub #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .diff   (diff),
      .borrow (borrow),
`ifdef SERIAL_SUB_SIGNED_EN
      .ovf    (ovf),
`endif
      .busy   (busy),
      .done   (done)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an op takes WIDTH+1 cycles after acceptance; results appear in the last one.
   int           m_rem    = 0;
   logic [W-1:0] m_diff   = '0;
   logic         m_borrow = 1'b0;
   logic         m_ovf    = 1'b0;
   logic [W-1:0] m_pdiff  = '0;
   logic         m_pbor   = 1'b0;
   logic         m_povf   = 1'b0;
   logic [W:0]   m_t;

   always @(posedge clk) begin
      if (rst) begin
         m_rem    = 0;
         m_diff   = '0;
         m_borrow = 1'b0;
         m_ovf    = 1'b0;
      end else if (m_rem == 0) begin
         if (start) begin
            m_t     = {1'b0, a} - {1'b0, b};
            m_pdiff = m_t[W-1:0];
            m_pbor  = m_t[W];
            m_povf  = (a[W-1] != b[W-1]) && (m_t[W-1] != a[W-1]);
            m_rem   = W + 1;
         end
      end else begin
         m_rem = m_rem - 1;
         if (m_rem == 1) begin
            m_diff   = m_pdiff;
            m_borrow = m_pbor;
            m_ovf    = m_povf;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("busy",   busy,   m_rem > 0);
      chk("done",   done,   m_rem == 1);
      chk("diff",   diff,   m_diff);
      chk("borrow", borrow, m_borrow);
`ifdef SERIAL_SUB_SIGNED_EN
      chk("ovf",    ovf,    m_ovf);
`endif
   end

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 40);
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [W-1:0] ed, input logic eb);
      int n;
      wait_idle();
      a     = ta;
      b     = tb_v;
      start = 1'b1;
      n     = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         start = 1'b0;
      end while (!done && n < 30);
      chk("lit_latency", n, 9);
      chk("lit_diff", diff, ed);
      chk("lit_borrow", borrow, eb);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int  seen_at;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed literal cases
      run_op(8'h05, 8'h03, 8'h02, 1'b0);
`ifdef SERIAL_SUB_SIGNED_EN
      chk("lit_ovf_0503", ovf, 0);
`endif
      run_op(8'h03, 8'h05, 8'hFE, 1'b1);
      run_op(8'hFF, 8'h01, 8'hFE, 1'b0);
      run_op(8'h00, 8'h00, 8'h00, 1'b0);
      run_op(8'h00, 8'hFF, 8'h01, 1'b1);
`ifdef SERIAL_SUB_SIGNED_EN
      run_op(8'h80, 8'h01, 8'h7F, 1'b0);
      chk("lit_ovf_8001", ovf, 1);
      run_op(8'h7F, 8'hFF, 8'h80, 1'b1);
      chk("lit_ovf_7fff", ovf, 1);
`endif

      // Start held high with operands changing every cycle
      wait_idle();
      a       = 8'h10;
      b       = 8'h01;
      start   = 1'b1;
      seen_at = -1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done && seen_at < 0) begin
            seen_at = i;
            chk("hold_diff", diff, 8'h0F);
            chk("hold_borrow", borrow, 0);
         end
         @(negedge clk);
         a = W'($urandom);
         b = W'($urandom);
      end
      chk("hold_latency", seen_at, 8);
      start = 1'b0;

      // Reset during the 4th SHIFT cycle
      wait_idle();
      a     = 8'h37;
      b     = 8'h12;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_diff", diff, 0);
      chk("abort_borrow", borrow, 0);
      rst = 1'b0;
      run_op(8'h37, 8'h12, 8'h25, 1'b0);

      // Random traffic including stray resets and start while busy
      wait_idle();
      repeat (800) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 99) == 0);
         start = ($urandom_range(0, 2) == 0);
         a     = pick();
         b     = pick();
      end
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      repeat (15) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
